// File: rtl/shift_issue_stage.sv
// shift_issue_stage
// Two-entry issue buffer between RV32 decode and the combinational shifter.
// Decodes SLL/SRL/SRA (register and immediate forms) at push time. It then
// presents the head entry to the shifter through registered output fields.
// Illegal shift encodings complete their handshake, are dropped, and raise a
// one-cycle err pulse on the following cycle.
module shift_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_shamt,
    input  logic        in_is_imm,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7_b5,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_tobeshifted,
    output logic [4:0]  out_amount,
    output logic [1:0]  out_left,
    output logic [4:0]  out_rd,
    output logic        err
);

    // Returns {legal, shift_code}.
    // Shift codes: 01 = logical left, 00 = logical right, 10 = arithmetic right.
    function automatic logic [2:0] decode_shift(input logic [2:0] funct3,
                                                input logic       f7b5);
        logic [2:0] res;
        case (funct3)
            3'b001:  res = f7b5 ? 3'b000 : 3'b101;
            3'b101:  res = f7b5 ? 3'b110 : 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Entry storage
    logic [31:0] val_r [2];
    logic [4:0]  amt_r [2];
    logic [1:0]  lft_r [2];
    logic [4:0]  tag_r [2];

    logic [1:0]  count_r;
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic        ready_r;
    logic        valid_r;
    logic        err_r;
    logic [31:0] head_val_r;
    logic [4:0]  head_amt_r;
    logic [1:0]  head_lft_r;
    logic [4:0]  head_tag_r;

    logic [2:0]  dec_s;
    logic        legal_s;
    logic [1:0]  new_left_s;
    logic [4:0]  new_amount_s;
    logic        accept_s;
    logic        store_s;
    logic        pop_s;
    logic [1:0]  count_next_s;
    logic        rd_ptr_next_s;
    logic        wr_ptr_next_s;
    logic        head_load_s;
    logic        head_from_in_s;
    logic        rs2_unused_s;

    // Only the low five bits of rs2 carry a shift amount.
    assign rs2_unused_s = ^in_rs2[31:5];

    // Decode the incoming operation and compute handshakes and next FIFO state.
    always_comb begin
        dec_s          = decode_shift(in_funct3, in_funct7_b5);
        legal_s        = dec_s[2];
        new_left_s     = dec_s[1:0];
        new_amount_s   = in_is_imm ? in_shamt : in_rs2[4:0];
        accept_s       = in_valid && ready_r && !flush;
        store_s        = accept_s && legal_s;
        pop_s          = valid_r && out_ready && !flush;
        count_next_s   = count_r;
        rd_ptr_next_s  = rd_ptr_r;
        wr_ptr_next_s  = wr_ptr_r;
        if (flush) begin
            count_next_s  = 2'd0;
            rd_ptr_next_s = 1'b0;
            wr_ptr_next_s = 1'b0;
        end else begin
            count_next_s  = count_r + {1'b0, store_s} - {1'b0, pop_s};
            rd_ptr_next_s = pop_s ? ~rd_ptr_r : rd_ptr_r;
            wr_ptr_next_s = store_s ? ~wr_ptr_r : wr_ptr_r;
        end
        // Head registers follow the entry that will be at the head next
        // cycle. They hold when the buffer empties or is flushed.
        head_load_s    = !flush && (count_next_s != 2'd0);
        head_from_in_s = store_s && (wr_ptr_r == rd_ptr_next_s);
    end

    // Pointer, occupancy and handshake status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= 2'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            ready_r  <= (count_next_s != 2'd2);
            valid_r  <= (count_next_s != 2'd0);
            err_r    <= accept_s && !legal_s;
        end
    end

    // Entry storage written on every legal accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                val_r[i] <= 32'd0;
                amt_r[i] <= 5'd0;
                lft_r[i] <= 2'd0;
                tag_r[i] <= 5'd0;
            end
        end else if (store_s) begin
            val_r[wr_ptr_r] <= in_rs1;
            amt_r[wr_ptr_r] <= new_amount_s;
            lft_r[wr_ptr_r] <= new_left_s;
            tag_r[wr_ptr_r] <= in_rd;
        end
    end

    // Registered head fields presented to the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_val_r <= 32'd0;
            head_amt_r <= 5'd0;
            head_lft_r <= 2'd0;
            head_tag_r <= 5'd0;
        end else if (head_load_s) begin
            if (head_from_in_s) begin
                head_val_r <= in_rs1;
                head_amt_r <= new_amount_s;
                head_lft_r <= new_left_s;
                head_tag_r <= in_rd;
            end else begin
                head_val_r <= val_r[rd_ptr_next_s];
                head_amt_r <= amt_r[rd_ptr_next_s];
                head_lft_r <= lft_r[rd_ptr_next_s];
                head_tag_r <= tag_r[rd_ptr_next_s];
            end
        end
    end

    assign in_ready        = ready_r;
    assign out_valid       = valid_r;
    assign err             = err_r;
    assign out_tobeshifted = head_val_r;
    assign out_amount      = head_amt_r;
    assign out_left        = head_lft_r;
    assign out_rd          = head_tag_r;

endmodule
